pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-low.
REQ-003 start_i  in  1  begin execution; sampled only in IDLE.
REQ-004 halt_i  in  1  request end of execution; sampled only in RUN.
REQ-005 idex_memread_i  in  1  instruction in EX is a load.
REQ-006 idex_rt_i  in  5  destination rt of instruction in EX.
REQ-007 ifid_rs_i, ifid_rt_i  in  5 each  source registers of instruction in ID.
REQ-008 branch_i, jump_i  in  1 each  branch/jump decode of instruction in ID.
REQ-009 eq_i  in  1  ID-stage register compare equal.
REQ-010 exmem_memread_i, exmem_memwrite_i  in  1 each  MEM-stage access pending.
REQ-011 dmem_ack_i  in  1  data memory completes current access this cycle.
REQ-012 pc_write_o, ifid_write_o  out  1 each  PC / IF-ID register enable.
REQ-013 ifid_flush_o  out  1  zero IF-ID next edge.
REQ-014 ctrl_zero_o  out  1  force bubble (all control zero) into ID-EX.
REQ-015 pipe_stall_o  out  1  freeze every pipeline register and PC.
REQ-016 pc_src_o  out  2  00 PC+4, 01 branch target, 10 jump target.
REQ-017 dmem_req_o  out  1  data memory access request.
REQ-018 stall_cnt_o  out  16  stall cycle count; done_o out 1 halted.

Function
REQ-019 FSM states IDLE, RUN, MEMWAIT, DRAIN, HALTED; state register only.
REQ-020 IDLE: pc_write_o=0, ifid_write_o=0, ctrl_zero_o=1, others 0; start_i=1 -> RUN.
REQ-021 mem_pend = exmem_memread_i | exmem_memwrite_i; dmem_req_o = mem_pend in RUN, MEMWAIT, DRAIN.
REQ-022 RUN, mem_pend=1, dmem_ack_i=0: pipe_stall_o=1, pc_write_o=0, ifid_write_o=0 same cycle; -> MEMWAIT.
REQ-023 MEMWAIT: pipe_stall_o=1 while dmem_ack_i=0; ack cycle pipe_stall_o=0, normal RUN outputs, -> RUN.
REQ-024 load_use = idex_memread_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
REQ-025 RUN, no memory stall, load_use=1: pc_write_o=0, ifid_write_o=0, ctrl_zero_o=1, pc_src_o=00, no flush; one cycle per detection.
REQ-026 RUN, no stall, jump_i=1: pc_src_o=10, ifid_flush_o=1.
REQ-027 RUN, no stall, no jump, branch_i & eq_i: pc_src_o=01, ifid_flush_o=1; branch not taken: pc_src_o=00, no flush.
REQ-028 Priority: memory stall > load_use > jump > branch; lower-priority actions suppressed.
REQ-029 Default RUN outputs: pc_write_o=1, ifid_write_o=1, others 0.
REQ-030 RUN, halt_i=1 and no memory stall: -> DRAIN, 2-bit drain counter loaded with 3; halt_i during memory stall deferred until stall ends.
REQ-031 DRAIN: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, ctrl_zero_o=1; memory stall rules of REQ-022/023 still apply and freeze the counter; counter decrements per unstalled cycle; at 0 -> HALTED.
REQ-032 HALTED: done_o=1, pc_write_o=0, ifid_write_o=0, ctrl_zero_o=1; terminal until reset; start_i ignored.
REQ-033 stall_cnt_o increments each cycle in RUN/MEMWAIT/DRAIN with pc_write_o=0; saturates at 16'hFFFF; not counted in IDLE/HALTED.
REQ-034 Outputs are combinational from state and inputs; no extra latency beyond one-edge state transition.

Reset
REQ-035 rst_i=0 at any time, including mid MEMWAIT/DRAIN: state=IDLE, drain counter=0, stall_cnt_o=0 immediately, no clock required.
REQ-036 During reset outputs equal IDLE values: pc_write_o=0, ifid_write_o=0, ctrl_zero_o=1, ifid_flush_o=0, pipe_stall_o=0, pc_src_o=00, dmem_req_o=0, done_o=0.
REQ-037 Leaving reset: first rising edge with rst_i=1 and start_i=1 enters RUN.

Verification
REQ-038 Reset then start_i=1 one cycle -> RUN next cycle, pc_write_o=1, ifid_write_o=1, stall_cnt_o=0.
REQ-039 idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> one cycle pc_write_o=0, ctrl_zero_o=1, stall_cnt_o=1; idex_rt_i=0 same case -> no stall.
REQ-040 exmem_memread_i=1, dmem_ack_i low 3 cycles then high -> pipe_stall_o=1 for 3 cycles, 0 on ack cycle, stall_cnt_o=3, back in RUN.
REQ-041 jump_i=1 and branch_i=1, eq_i=1 same cycle -> pc_src_o=10, ifid_flush_o=1; with load_use also set -> pc_src_o=00, no flush.
REQ-042 halt_i=1 in RUN -> 3 DRAIN cycles with ifid_flush_o=1, then done_o=1 and stays; start_i=1 in HALTED ignored.
REQ-043 rst_i=0 asynchronously mid-MEMWAIT -> outputs IDLE values before next edge, stall_cnt_o=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: hazard/stall/flush/PC-select decode plus a run/drain/halt FSM.
// Outputs are combinational from state and inputs (zero latency); data memory backpressure freezes the whole pipe.
module pipeline_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        eq_i,
  input  logic        exmem_memread_i,
  input  logic        exmem_memwrite_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        ctrl_zero_o,
  output logic        pipe_stall_o,
  output logic [1:0]  pc_src_o,
  output logic        dmem_req_o,
  output logic [15:0] stall_cnt_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_MEMWAIT = 3'd2,
    S_DRAIN   = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t      r_state;
  logic [1:0]  r_drain_cnt;
  logic [15:0] r_stall_cnt;

  logic w_mem_pend;
  logic w_load_use;
  logic w_active;
  logic w_mem_stall;
  logic w_run_like;
  logic w_cnt_inc;

  assign w_mem_pend = exmem_memread_i | exmem_memwrite_i;

  assign w_load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  assign w_active = (r_state == S_RUN) || (r_state == S_MEMWAIT) || (r_state == S_DRAIN);

  // MEMWAIT already owns an outstanding access, so only the ack matters there.
  always_comb begin
    w_mem_stall = 1'b0;
    case (r_state)
      S_RUN:     w_mem_stall = w_mem_pend & ~dmem_ack_i;
      S_MEMWAIT: w_mem_stall = ~dmem_ack_i;
      S_DRAIN:   w_mem_stall = w_mem_pend & ~dmem_ack_i;
      default:   w_mem_stall = 1'b0;
    endcase
  end

  assign w_run_like = ((r_state == S_RUN) || (r_state == S_MEMWAIT)) && !w_mem_stall;

  always_comb begin
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    ctrl_zero_o  = 1'b0;
    pipe_stall_o = 1'b0;
    pc_src_o     = PC_SEQ;
    dmem_req_o   = w_active & w_mem_pend;
    done_o       = 1'b0;

    case (r_state)
      S_IDLE: begin
        ctrl_zero_o = 1'b1;
      end
      S_RUN, S_MEMWAIT: begin
        if (w_mem_stall) begin
          pipe_stall_o = 1'b1;
        end else if (w_load_use) begin
          ctrl_zero_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          if (jump_i) begin
            pc_src_o     = PC_JUMP;
            ifid_flush_o = 1'b1;
          end else if (branch_i && eq_i) begin
            pc_src_o     = PC_BRANCH;
            ifid_flush_o = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_mem_stall) begin
          pipe_stall_o = 1'b1;
        end else begin
          ifid_flush_o = 1'b1;
          ctrl_zero_o  = 1'b1;
        end
      end
      S_HALTED: begin
        ctrl_zero_o = 1'b1;
        done_o      = 1'b1;
      end
      default: begin
        ctrl_zero_o = 1'b1;
      end
    endcase
  end

  assign w_cnt_inc   = w_active && !pc_write_o && (r_stall_cnt != 16'hFFFF);
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 2'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_cnt_inc) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
          end
        end
        S_RUN, S_MEMWAIT: begin
          // A halt seen while memory is stalled waits for the ack cycle.
          if (w_mem_stall) begin
            r_state <= S_MEMWAIT;
          end else if (halt_i) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 2'd3;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (!w_mem_stall) begin
            if (r_drain_cnt <= 2'd1) begin
              r_state     <= S_HALTED;
              r_drain_cnt <= 2'd0;
            end else begin
              r_drain_cnt <= r_drain_cnt - 2'd1;
            end
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_i)
    (r_state == S_DRAIN) |-> (r_drain_cnt != 2'd0));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench: the driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       start;
    logic       halt;
    logic       imr;
    logic [4:0] irt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       jp;
    logic       eq;
    logic       mr;
    logic       mw;
    logic       ack;
  } in_t;

  typedef struct packed {
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        cz;
    logic        ps;
    logic [1:0]  src;
    logic        dr;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0, halt_i = 1'b0, idex_memread_i = 1'b0;
  logic [4:0]  idex_rt_i = '0, ifid_rs_i = '0, ifid_rt_i = '0;
  logic        branch_i = 1'b0, jump_i = 1'b0, eq_i = 1'b0;
  logic        exmem_memread_i = 1'b0, exmem_memwrite_i = 1'b0, dmem_ack_i = 1'b0;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, ctrl_zero_o, pipe_stall_o;
  logic [1:0]  pc_src_o;
  logic        dmem_req_o, done_o;
  logic [15:0] stall_cnt_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;
  exp_t exp_q[$];
  int   id_q[$];

  pipeline_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .branch_i(branch_i), .jump_i(jump_i), .eq_i(eq_i),
    .exmem_memread_i(exmem_memread_i), .exmem_memwrite_i(exmem_memwrite_i),
    .dmem_ack_i(dmem_ack_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .ctrl_zero_o(ctrl_zero_o), .pipe_stall_o(pipe_stall_o), .pc_src_o(pc_src_o),
    .dmem_req_o(dmem_req_o), .stall_cnt_o(stall_cnt_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic in_t mk_in(input logic st, hl, imr, input logic [4:0] irt, rs, rt,
                                input logic br, jp, eq, mr, mw, ack);
    in_t v;
    v.start = st; v.halt = hl; v.imr = imr; v.irt = irt; v.rs = rs; v.rt = rt;
    v.br = br; v.jp = jp; v.eq = eq; v.mr = mr; v.mw = mw; v.ack = ack;
    return v;
  endfunction

  function automatic exp_t mk_ex(input logic pcw, ifw, fl, cz, ps, input logic [1:0] src,
                                 input logic dr, dn, input logic [15:0] cnt);
    exp_t e;
    e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.cz = cz; e.ps = ps;
    e.src = src; e.dr = dr; e.dn = dn; e.cnt = cnt;
    return e;
  endfunction

  // Canned expectations.
  function automatic exp_t ex_idle(input logic [15:0] cnt);
    return mk_ex(0, 0, 0, 1, 0, 2'b00, 0, 0, cnt);
  endfunction
  function automatic exp_t ex_run(input logic [15:0] cnt);
    return mk_ex(1, 1, 0, 0, 0, 2'b00, 0, 0, cnt);
  endfunction
  function automatic exp_t ex_lu(input logic [15:0] cnt);
    return mk_ex(0, 0, 0, 1, 0, 2'b00, 0, 0, cnt);
  endfunction
  function automatic exp_t ex_mstall(input logic [15:0] cnt);
    return mk_ex(0, 0, 0, 0, 1, 2'b00, 1, 0, cnt);
  endfunction
  function automatic exp_t ex_drain(input logic [15:0] cnt);
    return mk_ex(0, 0, 1, 1, 0, 2'b00, 0, 0, cnt);
  endfunction
  function automatic exp_t ex_halted(input logic [15:0] cnt);
    return mk_ex(0, 0, 0, 1, 0, 2'b00, 0, 1, cnt);
  endfunction

  in_t NOP;

  task automatic cyc(input logic rst, input in_t v, input exp_t e);
    @(posedge clk_i);
    #1;
    rst_i = rst;
    start_i = v.start; halt_i = v.halt; idex_memread_i = v.imr; idex_rt_i = v.irt;
    ifid_rs_i = v.rs; ifid_rt_i = v.rt; branch_i = v.br; jump_i = v.jp; eq_i = v.eq;
    exmem_memread_i = v.mr; exmem_memwrite_i = v.mw; dmem_ack_i = v.ack;
    exp_q.push_back(e);
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    exp_t a;
    int   id;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {pc_write_o, ifid_write_o, ifid_flush_o, ctrl_zero_o, pipe_stall_o,
            pc_src_o, dmem_req_o, done_o, stall_cnt_o};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL vec%0d: got pcw=%b ifw=%b fl=%b cz=%b ps=%b src=%b dr=%b dn=%b cnt=%0d, expected pcw=%b ifw=%b fl=%b cz=%b ps=%b src=%b dr=%b dn=%b cnt=%0d",
                 id, a.pcw, a.ifw, a.fl, a.cz, a.ps, a.src, a.dr, a.dn, a.cnt,
                 e.pcw, e.ifw, e.fl, e.cz, e.ps, e.src, e.dr, e.dn, e.cnt);
      end
    end
  end

  initial begin
    NOP = mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0);

    // Held in reset: start and memory activity must not leak through.
    cyc(0, NOP, ex_idle(0));
    cyc(0, mk_in(1,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_idle(0));
    cyc(1, NOP, ex_idle(0));
    cyc(1, mk_in(1,0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0), ex_idle(0));
    cyc(1, NOP, ex_run(0));
    // Load-use hazards on rs and on rt; rt==0 never stalls.
    cyc(1, mk_in(0,0,1,5'd8,5'd8,5'd0,0,0,0,0,0,0), ex_lu(0));
    cyc(1, NOP, ex_run(1));
    cyc(1, mk_in(0,0,1,5'd0,5'd0,5'd0,0,0,0,0,0,0), ex_run(1));
    cyc(1, mk_in(0,0,1,5'd5,5'd3,5'd5,0,0,0,0,0,0), ex_lu(1));
    cyc(1, NOP, ex_run(2));
    // Three-cycle memory wait, ack releases.
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_mstall(2));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_mstall(3));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_mstall(4));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,1), mk_ex(1,1,0,0,0,2'b00,1,0,16'd5));
    cyc(1, NOP, ex_run(5));
    // Memory stall outranks load-use, jump and halt; jump honored on the ack cycle.
    cyc(1, mk_in(0,1,1,5'd8,5'd8,5'd0,0,1,0,1,0,0), ex_mstall(5));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,1,0,0,1,1), mk_ex(1,1,1,0,0,2'b10,1,0,16'd6));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,1), mk_ex(1,1,0,0,0,2'b00,1,0,16'd6));
    // Control-flow priority.
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,1,1,1,0,0,0), mk_ex(1,1,1,0,0,2'b10,0,0,16'd6));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,1,0,1,0,0,0), mk_ex(1,1,1,0,0,2'b01,0,0,16'd6));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,1,0,0,0,0,0), ex_run(6));
    cyc(1, mk_in(0,0,1,5'd9,5'd0,5'd9,1,1,1,0,0,0), ex_lu(6));
    cyc(1, NOP, ex_run(7));
    // Halt: three unstalled drain cycles, one stalled cycle freezes the counter.
    cyc(1, mk_in(0,1,0,5'd0,5'd0,5'd0,0,0,0,0,0,0), ex_run(7));
    cyc(1, NOP, ex_drain(7));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_mstall(8));
    cyc(1, NOP, ex_drain(9));
    cyc(1, NOP, ex_drain(10));
    cyc(1, NOP, ex_halted(11));
    cyc(1, mk_in(1,0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0), ex_halted(11));
    cyc(1, mk_in(1,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_halted(11));
    cyc(1, NOP, ex_halted(11));
    // Restart, enter MEMWAIT, then drop reset mid-cycle.
    cyc(0, NOP, ex_idle(0));
    cyc(1, mk_in(1,0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0), ex_idle(0));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_mstall(0));
    cyc(1, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_mstall(1));
    cyc(0, mk_in(0,0,0,5'd0,5'd0,5'd0,0,0,0,1,0,0), ex_idle(0));
    cyc(1, NOP, ex_idle(0));
    cyc(1, mk_in(1,0,0,5'd0,5'd0,5'd0,0,0,0,0,0,0), ex_idle(0));
    cyc(1, NOP, ex_run(0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
